// File: rtl/seq_bus_arbiter.sv
// seq_bus_arbiter: round-robin burst scheduler for a shared tri-stated result bus with per-burst checksum.
// Optional feature macro REQ_DROP_ABORT_EN: dropping the granted Req during RUN ends the burst early with Abort.
module seq_bus_arbiter #(
    parameter int N_REQ = 4,
    parameter int BURST_LEN = 16,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_REQ-1:0] Req,
    input  logic [7:0]       Bus_In,
    output logic [N_REQ-1:0] Sel,
    output logic             Init,
    output logic [IDW-1:0]   Grant_Id,
    output logic             Busy,
    output logic [15:0]      Sum,
    output logic             Done,
    output logic             Abort
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
    localparam logic [IDW-1:0] PTR_RST = IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

    state_t state, state_nx;
    logic [IDW-1:0] ptr, pick, idx;
    logic [CW-1:0] cnt;
    logic [15:0] acc;
    logic early;

    // Select/init decode straight from state so a reset floats the unit bus immediately.
    assign Busy = (state != IDLE);
    assign Init = (state == INIT) || (state == DRAIN);
    assign Sel  = Busy ? (ONE << Grant_Id) : '0;

`ifdef REQ_DROP_ABORT_EN
    assign early = !Req[Grant_Id];
`else
    assign early = 1'b0;
`endif

    // Round-robin search upward from ptr+1; scanning backwards lets the highest-priority hit win.
    always_comb begin
        pick = ptr;
        idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = IDW'((int'(ptr) + i) % N_REQ);
            if (Req[idx]) pick = idx;
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= IDLE;
        else state <= state_nx;

    // Next-state: one init cycle, BURST_LEN run cycles (or fewer on an early exit), one drain cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (|Req) ? INIT : IDLE;
            INIT:    state_nx = RUN;
            RUN:     state_nx = (cnt == LAST || early) ? DRAIN : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Grant capture, beat counter, accumulator and the published checksum.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            Grant_Id <= '0;
            ptr <= PTR_RST;
            cnt <= '0;
            acc <= '0;
            Sum <= '0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (|Req) begin
                    Grant_Id <= pick;
                    ptr <= pick;
                end
                INIT: begin
                    acc <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt != '0) acc <= acc + {8'h00, Bus_In};
                end
                DRAIN: begin
                    Sum <= acc + {8'h00, Bus_In};
                    Done <= 1'b1;
                end
            endcase
        end

`ifdef REQ_DROP_ABORT_EN
    logic aborted, abort_q;

    // Remember an early exit from RUN so it can be flagged alongside Done.
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            aborted <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= (state == DRAIN) && aborted;
            if (state == INIT) aborted <= 1'b0;
            else if (state == RUN && early && cnt != LAST) aborted <= 1'b1;
        end

    assign Abort = abort_q;
`else
    assign Abort = 1'b0;
`endif
endmodule

// File: tb/tb_seq_bus_arbiter.sv
// tb_seq_bus_arbiter: scoreboard bench for seq_bus_arbiter with behavioural datapath units on the bus.
module tb_seq_bus_arbiter;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] Req = 4'b0;
    logic [7:0] Bus_In;
    logic [3:0] Sel;
    logic       Init;
    logic [1:0] Grant_Id;
    logic       Busy;
    logic [15:0] Sum;
    logic       Done;
    logic       Abort;

    seq_bus_arbiter #(.N_REQ(4), .BURST_LEN(16)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Bus_In(Bus_In), .Sel(Sel), .Init(Init),
        .Grant_Id(Grant_Id), .Busy(Busy), .Sum(Sum), .Done(Done), .Abort(Abort)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  gid;
        logic [15:0] sum;
        logic        abort;
        int          len;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int grants = 0;
    int dones = 0;
    int cur = 0;
    int last_len = 0;
    logic [7:0] base = 8'h05;
    logic [7:0] b [4];

    // Units: each registers base+index while selected and not in init, otherwise clears.
    always_ff @(posedge Clk)
        for (int u = 0; u < 4; u++) b[u] <= (Sel[u] && !Init) ? base + 8'(u) : 8'h00;

    // Only the selected unit drives the bus.
    always_comb begin
        Bus_In = 8'h00;
        for (int u = 0; u < 4; u++) if (Sel[u]) Bus_In = b[u];
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_burst(input logic [1:0] gid, input logic [15:0] sum, input logic ab, input int len);
        exp_t e;
        e.gid = gid;
        e.sum = sum;
        e.abort = ab;
        e.len = len;
        q.push_back(e);
    endtask

    // Monitor: tracks select run lengths and grants, scores every Done against the queue.
    always @(negedge Clk) begin
        exp_t e;
        if (Sel != 4'b0) begin
            if (cur == 0) grants++;
            cur++;
        end else if (cur != 0) begin
            last_len = cur;
            cur = 0;
        end
        chk("sel_onehot", int'($countones(Sel) <= 1), 1);
        chk("busy_vs_sel", int'(Busy), int'(Sel != 4'b0));
        if (Done) begin
            dones++;
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("grant_id", int'(Grant_Id), int'(e.gid));
                chk("sum", int'(Sum), int'(e.sum));
                chk("abort", int'(Abort), int'(e.abort));
                chk("burst_len", last_len, e.len);
            end
        end else chk("abort_without_done", int'(Abort), 0);
    end

    task automatic wait_grants(input int target);
        int n = 0;
        while (grants < target && n < 200) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("grant_wait", int'(grants >= target), 1);
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (dones < target && n < 200) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("done_wait", int'(dones >= target), 1);
    endtask

    task automatic burst(input logic [3:0] r, input int n);
        int g0 = grants;
        int d0 = dones;
        Req = r;
        wait_grants(g0 + n);
        Req = 4'b0;
        wait_dones(d0 + n);
        repeat (2) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2 Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int d0;
        #1 Rst = 1'b1;
        #1;
        chk("rst_sel", int'(Sel), 0);
        chk("rst_init", int'(Init), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_abort", int'(Abort), 0);
        chk("rst_sum", int'(Sum), 0);
        chk("rst_gid", int'(Grant_Id), 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        base = 8'h05;
        expect_burst(2'd0, 16'h0050, 1'b0, 18);
        burst(4'b0001, 1);

        do_reset();
        expect_burst(2'd0, 16'h0050, 1'b0, 18);
        expect_burst(2'd1, 16'h0060, 1'b0, 18);
        expect_burst(2'd2, 16'h0070, 1'b0, 18);
        expect_burst(2'd3, 16'h0080, 1'b0, 18);
        expect_burst(2'd0, 16'h0050, 1'b0, 18);
        burst(4'b1111, 5);

        do_reset();
        expect_burst(2'd2, 16'h0070, 1'b0, 18);
        burst(4'b0100, 1);
        expect_burst(2'd0, 16'h0050, 1'b0, 18);
        expect_burst(2'd2, 16'h0070, 1'b0, 18);
        burst(4'b0101, 2);

        do_reset();
        base = 8'hFF;
        expect_burst(2'd0, 16'h0FF0, 1'b0, 18);
        burst(4'b0001, 1);

        d0 = dones;
        Req = 4'b0010;
        wait_grants(grants + 1);
        Req = 4'b0;
        repeat (8) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("midrst_sel", int'(Sel), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_init", int'(Init), 0);
        chk("midrst_sum", int'(Sum), 0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midrst_no_done", dones, d0);

        base = 8'h05;
        expect_burst(2'd0, 16'h0050, 1'b0, 18);
        burst(4'b1111, 1);

`ifdef REQ_DROP_ABORT_EN
        expect_burst(2'd0, 16'h001E, 1'b1, 8);
`else
        expect_burst(2'd0, 16'h0050, 1'b0, 18);
`endif
        d0 = dones;
        Req = 4'b0001;
        wait_grants(grants + 1);
        repeat (6) @(negedge Clk);
        Req = 4'b0;
        wait_dones(d0 + 1);
        repeat (3) @(negedge Clk);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
